// File: rtl/udp_frame_reader.sv
// Read-side consumer for the framed byte ring buffer: issues reads, resynchronises on
// frame markers, caps frame length and streams bytes out through a 2-entry queue.
module udp_frame_reader #(
  parameter int MAX_LEN = 1472,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = 11
) (
  input  logic             rd_clk,
  input  logic             rst,
  output logic             buf_rd_en,
  input  logic [7:0]       buf_rddata,
  input  logic             buf_first,
  input  logic             buf_last,
  input  logic             buf_empty,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err_overlong,
  output logic             err_unterm
);

  typedef enum logic [1:0] {HUNT, PASS, DROP} state_t;

  localparam logic [LEN_W-1:0] LEN_TERM = LEN_W'(MAX_LEN - 1);

  state_t           state;
  logic [9:0]       q_mem [2];
  logic             q_rd;
  logic             q_wr;
  logic [1:0]       q_cnt;
  logic             inflight;
  logic [LEN_W-1:0] len;
  logic             pop;
  logic             push;
  logic             last_flag;

  assign out_valid = (q_cnt != 2'd0);
  assign {out_first, out_last, out_data} = q_mem[q_rd];
  assign pop = out_valid && out_ready;

  // Occupancy is taken after this cycle's pop so a draining queue keeps 1 byte/cycle.
  assign buf_rd_en = !rst && !buf_empty &&
                     (({1'b0, q_cnt} - {2'b0, pop} + {2'b0, inflight}) < 3'd2);

  assign push      = inflight && (buf_first || (state == PASS));
  assign last_flag = buf_last ||
                     ((state == PASS) && !buf_first && (len == LEN_TERM));

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state        <= HUNT;
      inflight     <= 1'b0;
      len          <= '0;
      q_rd         <= 1'b0;
      q_wr         <= 1'b0;
      q_cnt        <= 2'd0;
      q_mem[0]     <= '0;
      q_mem[1]     <= '0;
      frame_cnt    <= '0;
      drop_cnt     <= '0;
      err_overlong <= 1'b0;
      err_unterm   <= 1'b0;
    end else begin
      inflight     <= buf_rd_en;
      err_overlong <= 1'b0;
      err_unterm   <= 1'b0;
      if (pop) q_rd <= ~q_rd;
      if (push) begin
        q_mem[q_wr] <= {buf_first, last_flag, buf_rddata};
        q_wr        <= ~q_wr;
      end
      q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};

      if (inflight) begin
        case (state)
          HUNT, DROP: begin
            if (buf_first) begin
              len <= LEN_W'(1);
              if (buf_last) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                state     <= HUNT;
              end else begin
                state <= PASS;
              end
            end else begin
              drop_cnt <= drop_cnt + CNT_W'(1);
              if (state == DROP && buf_last) state <= HUNT;
            end
          end
          PASS: begin
            if (buf_first) begin
              // New start inside a frame: the old tail stays unmarked.
              err_unterm <= 1'b1;
              len        <= LEN_W'(1);
              if (buf_last) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                state     <= HUNT;
              end
            end else if (buf_last) begin
              frame_cnt <= frame_cnt + CNT_W'(1);
              state     <= HUNT;
            end else if (len == LEN_TERM) begin
              err_overlong <= 1'b1;
              state        <= DROP;
            end else begin
              len <= len + LEN_W'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
